rgb_slice_writer: RTL and testbench

Write side of the slice RAM. Receives the SBC's parallel RGB565 pixel stream and writes each complete slice of 1920 pixels (40 × 48) into the next slot of a ring of `SLICES_IN_RAM` slots. Tracks ring occupancy against slices consumed by the framebuffer, and generates the `stream_ready` sync that starts and stops the framebuffer's readout.

---
 rtl/spirose_pkg.sv | 25 ++
 rtl/slice_ring_ctrl.sv | 71 +++++++
 rtl/rgb_slice_writer.sv | 149 ++++++++++++++
 tb/tb_rgb_slice_writer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spirose_pkg.sv
// Shared slice geometry and writer state encoding for the slice RAM path.
// Latency: none (constants and types only).
// Backpressure: none; the framebuffer reads the same geometry from here.
package spirose_pkg;

    localparam int ROW_SIZE    = 40;
    localparam int COLUMN_SIZE = 48;
    localparam int IMAGE_SIZE  = ROW_SIZE * COLUMN_SIZE;

    // Pixel counter width: must hold IMAGE_SIZE itself (1920 needs 11 bits).
    localparam int PIX_W = $clog2(IMAGE_SIZE + 1);

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        WRITE   = 2'd1,
        COMMIT  = 2'd2
    } wr_state_t;

    // Address of a pixel inside a slot whose base has already been computed.
    function automatic logic [31:0] pix_addr(input logic [31:0] base,
                                             input logic [PIX_W-1:0] idx);
        return base + 32'(idx);
    endfunction

endpackage

// File: rtl/slice_ring_ctrl.sv
// Ring bookkeeping: occupancy counter, write slot/base pointer, stream_ready hysteresis.
// Latency: fill_level/stream_ready/slot_base update on the edge that samples commit/consume.
// Backpressure: none; consumption at empty is ignored, overflow is prevented by the writer.
module slice_ring_ctrl
    import spirose_pkg::*;
#(
    parameter int SLICES_IN_RAM  = 18,
    parameter int PRELOAD_SLICES = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        commit,
    input  logic        slice_consumed,
    output logic [7:0]  fill_level,
    output logic        stream_ready,
    output logic [31:0] slot_base
);

    localparam logic [7:0] LAST_SLOT = 8'(SLICES_IN_RAM - 1);
    localparam logic [7:0] PRELOAD   = 8'(PRELOAD_SLICES);

    logic [7:0] wr_slot;
    logic [7:0] fill_nxt;
    logic       ready_nxt;
    logic       consume_ok;

    // Next occupancy and ready level; a consume at empty never underflows.
    always_comb begin
        consume_ok = slice_consumed && (fill_level != 8'd0);
        fill_nxt   = fill_level;
        if (commit && !consume_ok) begin
            fill_nxt = fill_level + 8'd1;
        end else if (!commit && consume_ok) begin
            fill_nxt = fill_level - 8'd1;
        end
        ready_nxt = stream_ready;
        if (fill_nxt >= PRELOAD) begin
            ready_nxt = 1'b1;
        end else if (fill_nxt == 8'd0) begin
            ready_nxt = 1'b0;
        end
    end

    // Slot pointer and its base address advance together so no multiplier is needed.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_slot   <= 8'd0;
            slot_base <= 32'd0;
        end else if (commit) begin
            if (wr_slot == LAST_SLOT) begin
                wr_slot   <= 8'd0;
                slot_base <= 32'd0;
            end else begin
                wr_slot   <= wr_slot + 8'd1;
                slot_base <= slot_base + 32'(IMAGE_SIZE);
            end
        end
    end

    // Occupancy and hysteresis registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fill_level   <= 8'd0;
            stream_ready <= 1'b0;
        end else begin
            fill_level   <= fill_nxt;
            stream_ready <= ready_nxt;
        end
    end

endmodule

// File: rtl/rgb_slice_writer.sv
// Writes each complete 1920-pixel RGB565 slice into the next slot of the slice RAM ring.
// Latency: pixel sampled at edge N appears on ram_* after edge N+1 (input register + port register).
// Backpressure: none; a full ring drops the whole slice (err_overflow), a short slice is rewritten (err_short).
module rgb_slice_writer
    import spirose_pkg::*;
#(
    parameter int SLICES_IN_RAM  = 18,
    parameter int PRELOAD_SLICES = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        rgb_vsync,
    input  logic        rgb_de,
    input  logic [15:0] rgb_data,
    input  logic        slice_consumed,
    output logic [31:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    output logic        stream_ready,
    output logic [7:0]  fill_level,
    output logic        err_short,
    output logic        err_overflow
);

    localparam logic [7:0]       FULL_LEVEL = 8'(SLICES_IN_RAM);
    localparam logic [PIX_W-1:0] LAST_PIX   = PIX_W'(IMAGE_SIZE - 1);

    wr_state_t        state;
    wr_state_t        state_nxt;
    logic             vs_q;
    logic             vs_qq;
    logic             de_q;
    logic [15:0]      data_q;
    logic [PIX_W-1:0] pix_cnt;
    logic             dropped;
    logic             vs_rise;
    logic             start;
    logic             is_short;
    logic             accept;
    logic             ring_full;
    logic             commit;
    logic [31:0]      slot_base;

    // Input register stage; vsync gets a second stage for edge detection.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vs_q   <= 1'b0;
            vs_qq  <= 1'b0;
            de_q   <= 1'b0;
            data_q <= 16'd0;
        end else begin
            vs_q   <= rgb_vsync;
            vs_qq  <= vs_q;
            de_q   <= rgb_de;
            data_q <= rgb_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= WAIT_VS;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle decode; a vsync edge in WRITE restarts the slice.
    always_comb begin
        vs_rise   = vs_q && !vs_qq;
        ring_full = (fill_level == FULL_LEVEL);
        start     = 1'b0;
        is_short  = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        state_nxt = state;
        case (state)
            WAIT_VS: begin
                if (vs_rise) begin
                    start     = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (vs_rise) begin
                    start     = 1'b1;
                    is_short  = 1'b1;
                    state_nxt = WRITE;
                end else if (de_q) begin
                    accept = 1'b1;
                    if (pix_cnt == LAST_PIX) begin
                        state_nxt = COMMIT;
                    end
                end
            end
            COMMIT: begin
                commit    = !dropped;
                state_nxt = WAIT_VS;
            end
            default: begin
                state_nxt = WAIT_VS;
            end
        endcase
    end

    // Pixel counter, drop flag, RAM port and error pulse registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pix_cnt      <= '0;
            dropped      <= 1'b0;
            ram_addr     <= 32'd0;
            ram_wdata    <= 16'd0;
            ram_we       <= 1'b0;
            err_short    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            ram_we       <= 1'b0;
            err_short    <= 1'b0;
            err_overflow <= 1'b0;
            if (start) begin
                pix_cnt      <= '0;
                dropped      <= ring_full;
                err_overflow <= ring_full;
                err_short    <= is_short;
            end else if (accept) begin
                pix_cnt <= pix_cnt + 1'b1;
                if (!dropped) begin
                    ram_we    <= 1'b1;
                    ram_addr  <= pix_addr(slot_base, pix_cnt);
                    ram_wdata <= data_q;
                end
            end
        end
    end

    slice_ring_ctrl #(
        .SLICES_IN_RAM  (SLICES_IN_RAM),
        .PRELOAD_SLICES (PRELOAD_SLICES)
    ) u_ring (
        .clk            (clk),
        .nrst           (nrst),
        .commit         (commit),
        .slice_consumed (slice_consumed),
        .fill_level     (fill_level),
        .stream_ready   (stream_ready),
        .slot_base      (slot_base)
    );

endmodule

// File: tb/tb_rgb_slice_writer.sv
// Directed sequence with random pixel data and de gaps against a slice-level model.
// Latency: checks are taken after each step has settled.
// Backpressure: none exercised beyond ring-full dropping.
module tb_rgb_slice_writer;

    localparam int SLICES = 18;
    localparam int PRE    = 4;
    localparam int IMG    = 1920;

    logic        clk = 1'b0;
    logic        nrst;
    logic        rgb_vsync;
    logic        rgb_de;
    logic [15:0] rgb_data;
    logic        slice_consumed;
    logic [31:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic        stream_ready;
    logic [7:0]  fill_level;
    logic        err_short;
    logic        err_overflow;

    rgb_slice_writer #(
        .SLICES_IN_RAM  (SLICES),
        .PRELOAD_SLICES (PRE)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .rgb_vsync      (rgb_vsync),
        .rgb_de         (rgb_de),
        .rgb_data       (rgb_data),
        .slice_consumed (slice_consumed),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_we         (ram_we),
        .stream_ready   (stream_ready),
        .fill_level     (fill_level),
        .err_short      (err_short),
        .err_overflow   (err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];

    int n_cmp      = 0;
    int n_fail     = 0;
    int n_short_ob = 0;
    int n_ovf_ob   = 0;

    // Slice-level reference model.
    int m_fill  = 0;
    int m_slot  = 0;
    int m_short = 0;
    int m_ovf   = 0;
    bit m_ready = 0;
    bit m_drop  = 0;

    // Record every write strobe and error pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (nrst === 1'b1) begin
            if (ram_we === 1'b1) begin
                obs_q.push_back('{addr: ram_addr, data: ram_wdata});
            end
            if (err_short === 1'b1) n_short_ob++;
            if (err_overflow === 1'b1) n_ovf_ob++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            if (n_fail <= 20) $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        int n;
        check({tag, "_wr_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
            check({tag, "_data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_fill"}, 32'(fill_level), 32'(m_fill));
        check({tag, "_ready"}, 32'(stream_ready), 32'(m_ready));
        check({tag, "_nshort"}, 32'(n_short_ob), 32'(m_short));
        check({tag, "_novf"}, 32'(n_ovf_ob), 32'(m_ovf));
        check_writes(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, ram_addr, 32'd0);
        check({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
        check({tag, "_we"}, 32'(ram_we), 32'd0);
        check({tag, "_ready"}, 32'(stream_ready), 32'd0);
        check({tag, "_fill"}, 32'(fill_level), 32'd0);
        check({tag, "_short"}, 32'(err_short), 32'd0);
        check({tag, "_ovf"}, 32'(err_overflow), 32'd0);
    endtask

    function automatic void m_commit();
        m_slot = (m_slot + 1) % SLICES;
        m_fill++;
        if (m_fill >= PRE) m_ready = 1;
    endfunction

    function automatic void m_consume();
        if (m_fill > 0) m_fill--;
        if (m_fill == 0) m_ready = 0;
    endfunction

    // One-cycle vsync; the full check is taken from the model's current occupancy.
    task automatic start_slice();
        rgb_de    = 1'b0;
        rgb_vsync = 1'b1;
        tick();
        rgb_vsync = 1'b0;
        m_drop = (m_fill == SLICES);
        if (m_drop) m_ovf++;
    endtask

    // Raster-order pixels with random data and occasional idle cycles.
    task automatic pixels(input int n, input bit gap_last);
        for (int i = 0; i < n; i++) begin
            rgb_de   = 1'b1;
            rgb_data = 16'($urandom);
            if (!m_drop) exp_q.push_back('{addr: 32'(m_slot * IMG + i), data: rgb_data});
            tick();
            if ((gap_last || i != n - 1) && $urandom_range(7) == 0) begin
                rgb_de = 1'b0;
                tick();
            end
        end
        rgb_de = 1'b0;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic full_slice();
        start_slice();
        pixels(IMG, 1'b1);
        settle(8);
        if (!m_drop) m_commit();
    endtask

    task automatic consume_pulse();
        slice_consumed = 1'b1;
        tick();
        slice_consumed = 1'b0;
        tick();
        m_consume();
    endtask

    initial begin
        nrst = 1'b0;
        rgb_vsync = 1'b0;
        rgb_de = 1'b0;
        rgb_data = 16'd0;
        slice_consumed = 1'b0;
        settle(3);
        check_reset_outputs("reset");
        nrst = 1'b1;
        settle(3);

        // Short slice followed by a full one: both land at base 0.
        start_slice();
        pixels(1000, 1'b1);
        settle(3);
        start_slice();
        m_short++;
        pixels(IMG, 1'b1);
        settle(8);
        m_commit();
        check_status("short");

        // Fill to the preload threshold; ready rises only with the 4th commit.
        full_slice();
        full_slice();
        check_status("pre3");
        full_slice();
        check_status("pre4");

        // Fill the ring, then one slice too many.
        for (int s = 0; s < SLICES - PRE; s++) full_slice();
        check_status("full");
        full_slice();
        check_status("overflow");

        // Free one slot; next slice wraps to slot 0.
        consume_pulse();
        check_status("consume1");
        full_slice();
        check_status("wrap");

        // Consume on exactly the commit cycle.
        consume_pulse();
        start_slice();
        pixels(IMG, 1'b0);
        tick();
        slice_consumed = 1'b1;
        tick();
        slice_consumed = 1'b0;
        settle(6);
        m_commit();
        m_consume();
        check_status("simul");

        // Drain to empty, one extra consume, then a single commit.
        while (m_fill > 0) begin
            consume_pulse();
            check("drain_fill", 32'(fill_level), 32'(m_fill));
            check("drain_ready", 32'(stream_ready), 32'(m_ready));
        end
        consume_pulse();
        check_status("drained");
        full_slice();
        check_status("refill1");

        // Reset in the middle of a slice.
        start_slice();
        pixels(500, 1'b1);
        settle(4);
        check_writes("partial");
        nrst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        settle(2);
        nrst = 1'b1;
        m_fill = 0;
        m_slot = 0;
        m_ready = 0;
        settle(2);
        full_slice();
        check_status("postreset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
